// File: rtl/serializer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : serializer_arbiter
// Function : Round-robin arbiter that feeds one shared serializer. It filters
//            illegal bit counts and gives up if the serializer never goes busy.
// Revision : 1.0  initial release
// ============================================================================
module serializer_arbiter #(
    parameter int N_REQ        = 4,
    parameter int DATA_W       = 16,
    parameter int MOD_W        = 4,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N_REQ*DATA_W-1:0]  req_data_i,
    input  logic [N_REQ*MOD_W-1:0]   req_mod_i,
    input  logic [N_REQ-1:0]         req_val_i,
    output logic [N_REQ-1:0]         req_rdy_o,
    output logic [DATA_W-1:0]        ser_data_o,
    output logic [MOD_W-1:0]         ser_mod_o,
    output logic                     ser_val_o,
    input  logic                     ser_busy_i,
    output logic [$clog2(N_REQ)-1:0] grant_id_o,
    output logic                     drop_o,
    output logic                     timeout_o
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(BUSY_TIMEOUT);
    localparam logic [ID_W-1:0]  C_PTR_RST = ID_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t            state_q;
    logic [ID_W-1:0]   ptr_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              w_any;
    logic [ID_W-1:0]   w_idx;
    logic [ID_W-1:0]   w_win;
    logic [DATA_W-1:0] w_win_data;
    logic [MOD_W-1:0]  w_win_mod;
    logic              w_win_illegal;
    logic              w_accept;
    logic [CNT_W-1:0]  w_cnt_inc;

    // Cyclic search starting just past the last served requester
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_idx = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_idx = ID_W'((int'(ptr_q) + i) % N_REQ);
            if (!w_any && req_val_i[w_idx]) begin
                w_any = 1'b1;
                w_win = w_idx;
            end
        end
    end

    assign w_win_data    = req_data_i[w_win*DATA_W +: DATA_W];
    assign w_win_mod     = req_mod_i[w_win*MOD_W +: MOD_W];
    assign w_win_illegal = (w_win_mod == MOD_W'(1)) || (w_win_mod == MOD_W'(2));
    assign w_accept      = (state_q == S_IDLE) && w_any && !rst_i;
    assign w_cnt_inc     = cnt_q + 1'b1;
    assign req_rdy_o     = w_accept ? ({{(N_REQ-1){1'b0}}, 1'b1} << w_win) : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            ptr_q      <= C_PTR_RST;
            cnt_q      <= '0;
            ser_data_o <= '0;
            ser_mod_o  <= '0;
            ser_val_o  <= 1'b0;
            grant_id_o <= '0;
            drop_o     <= 1'b0;
            timeout_o  <= 1'b0;
        end else begin
            ser_val_o <= 1'b0;
            drop_o    <= 1'b0;
            timeout_o <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (w_accept) begin
                        ser_data_o <= w_win_data;
                        ser_mod_o  <= w_win_mod;
                        grant_id_o <= w_win;
                        ptr_q      <= w_win;
                        // Filtered requests still rotate priority but never reach the serializer
                        if (w_win_illegal) begin
                            drop_o <= 1'b1;
                        end else begin
                            ser_val_o <= 1'b1;
                            state_q   <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (ser_busy_i) begin
                        state_q <= S_WAIT_DONE;
                    end else begin
                        cnt_q <= w_cnt_inc;
                        if (w_cnt_inc == C_TIMEOUT) begin
                            timeout_o <= 1'b1;
                            state_q   <= S_IDLE;
                        end
                    end
                end
                S_WAIT_DONE: begin
                    if (!ser_busy_i) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/serializer_arbiter.md
# serializer_arbiter

Round-robin arbiter sharing one `serializer` instance between `N_REQ` word producers. Each producer offers a 16-bit word plus a bit count over a valid/ready handshake. The arbiter picks one request, forwards it to the serializer as a single-cycle valid pulse, and waits until the serializer's `busy` drops before granting again. Requests with the serializer's illegal bit counts are filtered out and never issued.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 16: word width; matches the serializer data input.
- `MOD_W`, 4: bit-count width; matches the serializer mod input.
- `BUSY_TIMEOUT`, 4: maximum number of cycles to wait for `ser_busy_i` to rise after an issue; 1..15.

- `clk_i` in 1: single clock.
- `rst_i` in 1: synchronous reset, active high.
- `req_data_i` in `N_REQ*DATA_W`: word of requester k at bits [k*DATA_W +: DATA_W].
- `req_mod_i` in `N_REQ*MOD_W`: bit count of requester k. 0 means a full word.
- `req_val_i` in `N_REQ`: request pending, one bit per requester.
- `req_rdy_o` out `N_REQ`: one-hot accept pulse.
- `ser_data_o` out `DATA_W`: word to the serializer.
- `ser_mod_o` out `MOD_W`: bit count to the serializer.
- `ser_val_o` out 1: single-cycle issue strobe.
- `ser_busy_i` in 1: serializer busy flag.
- `grant_id_o` out `$clog2(N_REQ)`: index of the last accepted requester.
- `drop_o` out 1: pulse when a request is filtered.
- `timeout_o` out 1: pulse when `ser_busy_i` never rose after an issue.

## Operation
- **States:** IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- **IDLE**
  - The winner is the first k with `req_val_i[k]=1`, searching cyclically from `ptr+1`.
  - `req_rdy_o[k]` is driven combinationally: `req_rdy_o = onehot(winner)` in IDLE when any request is valid, and 0 in every other state.
  - On the accept edge: latch data and mod, set `grant_id_o=k`, set `ptr=k`.
  - If the latched mod is 1 or 2: pulse `drop_o` the next cycle and stay in IDLE.
  - Otherwise go to ISSUE.
- **ISSUE** (one cycle): `ser_val_o=1` with `ser_data_o`/`ser_mod_o` from the latch. Then go to WAIT_BUSY and clear the timeout counter.
- **WAIT_BUSY**
  - If `ser_busy_i=1`, go to WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches `BUSY_TIMEOUT`, pulse `timeout_o` and go to IDLE.
- **WAIT_DONE:** when `ser_busy_i=0`, go to IDLE.
- **Producer rules:** a producer holds `req_val_i`, data and mod stable until it sees `req_rdy_o`. Dropping `req_val_i` before the grant is allowed and simply withdraws the request.
- **Fairness:**
  - A requester that has just been served has the lowest priority in the next arbitration.
  - With all N valid, grants rotate 0,1,…,N-1,0.
  - A filtered request advances `ptr` in the same way.
- **Latched values:** `ser_data_o`/`ser_mod_o` hold the latched values outside ISSUE. The serializer qualifies them only with `ser_val_o`.

## Timing
- **Reset values:** state=IDLE, `ptr=N_REQ-1` (requester 0 wins first), every output 0, latch 0, counter 0.
- **Reset during any state:** IDLE on the next edge. No `req_rdy_o` while `rst_i=1`. Any in-flight transfer is abandoned with no `drop_o` or `timeout_o`.
- **Accept-to-issue latency:** accept at edge t, `ser_val_o` high for cycle t..t+1 only.
- **Serializer contract:** `ser_busy_i` rises 1 cycle after `ser_val_o` and falls after the last bit is shifted out.
- **Minimum spacing:** two issues are at least 4 cycles apart (ISSUE, WAIT_BUSY, ≥1 WAIT_DONE, IDLE accept).
- **Back-to-back:** the arbiter returns to IDLE on the edge where `ser_busy_i=0` is sampled. A pending request is accepted in the IDLE cycle that follows.
- **`ser_busy_i` already high in WAIT_BUSY's first cycle:** go directly to WAIT_DONE.
- **Consecutive filtered requests:** one per cycle, each with its own `drop_o` pulse.
- **Pulse alignment:** `drop_o` and `timeout_o` are registered, one cycle wide, and never coincide with `ser_val_o`.

## Test plan
- **Single request:** after reset, `req_val_i=4'b0001`, data 16'hA5C3, mod 0; serializer busy 16 cycles. Required:
  - `req_rdy_o=0001` for one cycle.
  - `ser_val_o` one cycle later with 16'hA5C3 and mod 0.
  - Next accept only after busy falls.
- **All four requesters valid continuously:** grants come in order 0,1,2,3,0. `grant_id_o` follows; no requester is served twice before the others.
- **Filtered request:** requester 2 offers mod 1, then mod 2. Required: two `req_rdy_o=0100` pulses, two `drop_o` pulses, no `ser_val_o`; `ptr` advances so requester 3 wins next.
- **Serializer never busy, `BUSY_TIMEOUT=4`:** `timeout_o` pulses exactly 4 cycles after WAIT_BUSY is entered, then the arbiter accepts the next request.
- **Reset mid-operation:** assert `rst_i` during WAIT_DONE with requests pending. Required: all outputs 0 and no rdy pulses during reset; after release, requester 0 (if valid) wins first.
- **Withdrawn request:** requester 1 raises and drops `req_val_i` while the arbiter is busy. Required: no grant to requester 1, and the rotation for the other requesters is unaffected.
